// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game controller and its surroundings.
//  Inputs to the controller: button levels, frame boundary pulse, per-pixel activity flags.
//  Outputs from the controller: direction, update, collision, game_state, score.
// Modports:
//  master - the controller (drives the control stream, reads pixel/button inputs)
//  slave  - the environment (buttons, VGA timing, renderers)
interface snake_game_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       frame_end;
    logic       snake_head_active;
    logic       snake_body_active;
    logic       apple_active;
    logic       wall_active;
    logic [2:0] direction;
    logic       update;
    logic [1:0] collision;
    logic [1:0] game_state;
    logic [7:0] score;

    modport master (
        input  btn_up, btn_down, btn_left, btn_right, frame_end,
        input  snake_head_active, snake_body_active, apple_active, wall_active,
        output direction, update, collision, game_state, score
    );

    modport slave (
        output btn_up, btn_down, btn_left, btn_right, frame_end,
        output snake_head_active, snake_body_active, apple_active, wall_active,
        input  direction, update, collision, game_state, score
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game controller: turns button presses, VGA frame boundaries and renderer pixel
// activity into the direction/update/collision/game_state/score control stream.
// Ports:
//  clk      - system/pixel clock
//  reset_n  - asynchronous active-low reset
//  bus      - snake_game_ctrl_if.master (buttons, frame_end, pixel flags in; control stream out)
module snake_game_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned GAMEOVER_FRAMES = 60,
    parameter int unsigned CNT_BIT         = 6
) (
    input logic              clk,
    input logic              reset_n,
    snake_game_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StPlay     = 2'b01,
        StGameOver = 2'b11
    } state_e;

    localparam logic [2:0] DirNone  = 3'd0;
    localparam logic [2:0] DirUp    = 3'd1;
    localparam logic [2:0] DirDown  = 3'd2;
    localparam logic [2:0] DirLeft  = 3'd3;
    localparam logic [2:0] DirRight = 3'd4;

    localparam logic [1:0] ColNone  = 2'b00;
    localparam logic [1:0] ColFatal = 2'b01;
    localparam logic [1:0] ColApple = 2'b10;

    localparam logic [CNT_BIT-1:0] StepLast = CNT_BIT'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_BIT-1:0] OverLast = CNT_BIT'(GAMEOVER_FRAMES - 1);

    state_e             state_q, state_d;
    logic [3:0]         btn_meta_q, btn_sync_q, btn_prev_q;
    logic [3:0]         btn_raw, btn_edge;
    logic [2:0]         press_dir;
    logic               any_press;
    logic [2:0]         dir_q, dir_d;
    logic [2:0]         pend_q, pend_d;
    logic [CNT_BIT-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_BIT-1:0] over_cnt_q, over_cnt_d;
    logic               hit_fatal_q, hit_fatal_d;
    logic               hit_apple_q, hit_apple_d;
    logic               upd_arm_q, upd_arm_d;
    logic               update_q, update_d;
    logic [1:0]         collision_q, collision_d;
    logic [7:0]         score_q, score_d;
    logic               fatal_seen, apple_seen;

    assign btn_raw  = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
    assign btn_edge = btn_sync_q & ~btn_prev_q;
    assign any_press = |btn_edge;

    // Simultaneous edges resolve UP > DOWN > LEFT > RIGHT.
    always_comb begin
        press_dir = DirNone;
        if (btn_edge[0])      press_dir = DirUp;
        else if (btn_edge[1]) press_dir = DirDown;
        else if (btn_edge[2]) press_dir = DirLeft;
        else if (btn_edge[3]) press_dir = DirRight;
    end

    function automatic logic is_reverse(input logic [2:0] a, input logic [2:0] b);
        return (a == DirUp   && b == DirDown)  || (a == DirDown  && b == DirUp) ||
               (a == DirLeft && b == DirRight) || (a == DirRight && b == DirLeft);
    endfunction

    // A hit registered in the frame_end cycle itself still belongs to that frame.
    assign fatal_seen = hit_fatal_q | (bus.snake_head_active &
                        (bus.wall_active | bus.snake_body_active));
    assign apple_seen = hit_apple_q | (bus.snake_head_active & bus.apple_active);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        step_cnt_d  = step_cnt_q;
        over_cnt_d  = over_cnt_q;
        hit_fatal_d = 1'b0;
        hit_apple_d = 1'b0;
        upd_arm_d   = 1'b0;
        update_d    = 1'b0;
        collision_d = ColNone;
        score_d     = score_q;

        unique case (state_q)
            StIdle: begin
                if (any_press) begin
                    state_d    = StPlay;
                    dir_d      = press_dir;
                    pend_d     = press_dir;
                    score_d    = 8'd0;
                    step_cnt_d = '0;
                end
            end
            StPlay: begin
                hit_fatal_d = fatal_seen;
                hit_apple_d = apple_seen;
                // Update trails the direction commit by one cycle.
                update_d    = upd_arm_q;
                if (any_press && !is_reverse(press_dir, dir_q)) begin
                    pend_d = press_dir;
                end
                if (bus.frame_end) begin
                    hit_fatal_d = 1'b0;
                    hit_apple_d = 1'b0;
                    if (fatal_seen) begin
                        collision_d = ColFatal;
                        state_d     = StGameOver;
                        dir_d       = DirNone;
                        step_cnt_d  = '0;
                        over_cnt_d  = '0;
                        update_d    = 1'b0;
                    end else begin
                        if (apple_seen) begin
                            collision_d = ColApple;
                            if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        end
                        if (step_cnt_q == StepLast) begin
                            step_cnt_d = '0;
                            dir_d      = pend_q;
                            upd_arm_d  = 1'b1;
                        end else begin
                            step_cnt_d = step_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StGameOver: begin
                if (bus.frame_end) begin
                    if (over_cnt_q == OverLast) begin
                        state_d    = StIdle;
                        over_cnt_d = '0;
                    end else begin
                        over_cnt_d = over_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            btn_prev_q  <= '0;
            dir_q       <= DirNone;
            pend_q      <= DirNone;
            step_cnt_q  <= '0;
            over_cnt_q  <= '0;
            hit_fatal_q <= 1'b0;
            hit_apple_q <= 1'b0;
            upd_arm_q   <= 1'b0;
            update_q    <= 1'b0;
            collision_q <= ColNone;
            score_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            btn_meta_q  <= btn_raw;
            btn_sync_q  <= btn_meta_q;
            btn_prev_q  <= btn_sync_q;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            step_cnt_q  <= step_cnt_d;
            over_cnt_q  <= over_cnt_d;
            hit_fatal_q <= hit_fatal_d;
            hit_apple_q <= hit_apple_d;
            upd_arm_q   <= upd_arm_d;
            update_q    <= update_d;
            collision_q <= collision_d;
            score_q     <= score_d;
        end
    end

    assign bus.direction  = dir_q;
    assign bus.update     = update_q;
    assign bus.collision  = collision_q;
    assign bus.game_state = state_q;
    assign bus.score      = score_q;
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios plus random frames, checked
// against a per-frame behavioural model of the game rules.
module tb_snake_game_ctrl;
    localparam int FPS   = 8;
    localparam int GOF   = 60;
    localparam int FLEN  = 6;

    logic clk;
    logic reset_n;
    snake_game_ctrl_if bus ();

    snake_game_ctrl #(
        .FRAMES_PER_STEP(FPS),
        .GAMEOVER_FRAMES(GOF),
        .CNT_BIT        (6)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: state 0 idle, 1 play, 3 game over; frames counted since last move.
    int m_state, m_dir, m_pend, m_score, m_frames, m_over;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0; m_dir = 0; m_pend = 0; m_score = 0; m_frames = 0; m_over = 0;
    endtask

    function automatic int prio(input logic [3:0] m);
        if (m[0]) return 1;
        if (m[1]) return 2;
        if (m[2]) return 3;
        if (m[3]) return 4;
        return 0;
    endfunction

    function automatic bit opposite(input int a, input int b);
        return (a + b == 3 && a != 0 && b != 0 && a <= 2 && b <= 2) || (a + b == 7 && a >= 3);
    endfunction

    task automatic set_pix(input bit h, input bit b, input bit a, input bit w);
        bus.snake_head_active = h;
        bus.snake_body_active = b;
        bus.apple_active      = a;
        bus.wall_active       = w;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".state"}, {6'd0, bus.game_state}, 8'(m_state));
        chk({tag, ".dir"}, {5'd0, bus.direction}, 8'(m_dir));
        chk({tag, ".score"}, bus.score, 8'(m_score));
    endtask

    // Press a button combination, release, let the edge settle, then check.
    task automatic press(input logic [3:0] m);
        int d;
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = m;
        repeat (4) cyc();
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 4'b0;
        repeat (3) cyc();
        d = prio(m);
        if (m_state == 0) begin
            m_state = 1; m_dir = d; m_pend = d; m_score = 0; m_frames = 0;
        end else if (m_state == 1) begin
            if (!opposite(d, m_dir)) m_pend = d;
        end
        check_outputs("press");
        chk("press.update", {7'd0, bus.update}, 8'd0);
        chk("press.collision", {6'd0, bus.collision}, 8'd0);
    endtask

    // kind: 0 quiet, 1 apple 3px, 2 wall, 3 wall+apple, 4 random, 5 body on frame_end cycle,
    // 6 apple on frame_end cycle, 7 flags without head overlap. rst_mid resets during the pulse.
    task automatic frame(input int kind, input bit rst_mid = 1'b0);
        bit fatal, apple, h, b, a, w;
        int exp_col, exp_upd;
        fatal = 0; apple = 0;
        for (int c = 0; c < FLEN; c++) begin
            h = 0; b = 0; a = 0; w = 0;
            case (kind)
                1: begin h = (c >= 1 && c <= 3); a = h; end
                2: begin h = (c == 2); w = h; end
                3: begin h = (c == 1 || c == 3); w = (c == 1); a = (c == 3); end
                4: begin
                    h = ($urandom % 4) == 0;
                    b = ($urandom % 64) == 0;
                    w = ($urandom % 64) == 0;
                    a = ($urandom % 4) == 0;
                end
                5: begin h = (c == FLEN - 1); b = h; end
                6: begin h = (c == FLEN - 1); a = h; end
                7: begin h = (c == 1); w = (c == 2); b = (c == 3); a = (c == 4); end
                default: ;
            endcase
            if (h && (w || b)) fatal = 1;
            if (h && a) apple = 1;
            set_pix(h, b, a, w);
            bus.frame_end = (c == FLEN - 1);
            cyc();
        end
        set_pix(0, 0, 0, 0);
        bus.frame_end = 1'b0;

        exp_col = 0; exp_upd = 0;
        if (m_state == 1) begin
            if (fatal) begin
                exp_col = 1; m_state = 3; m_dir = 0; m_frames = 0; m_over = 0;
            end else begin
                if (apple) begin
                    exp_col = 2;
                    if (m_score < 255) m_score++;
                end
                m_frames++;
                if (m_frames == FPS) begin
                    m_frames = 0; m_dir = m_pend; exp_upd = 1;
                end
            end
        end else if (m_state == 3) begin
            m_over++;
            if (m_over == GOF) begin m_state = 0; m_over = 0; end
        end

        chk("frame.collision", {6'd0, bus.collision}, 8'(exp_col));
        chk("frame.update_early", {7'd0, bus.update}, 8'd0);
        check_outputs("frame");
        if (rst_mid) begin
            reset_n = 1'b0;
            #1;
            model_reset();
            check_outputs("rst_mid");
            chk("rst_mid.update", {7'd0, bus.update}, 8'd0);
            chk("rst_mid.collision", {6'd0, bus.collision}, 8'd0);
            cyc();
            reset_n = 1'b1;
            cyc();
            chk("rst_rel.state", {6'd0, bus.game_state}, 8'd0);
        end else begin
            cyc();
            chk("frame.update", {7'd0, bus.update}, 8'(exp_upd));
            chk("frame.collision_clr", {6'd0, bus.collision}, 8'd0);
            if (exp_upd == 1) chk("frame.dir_at_update", {5'd0, bus.direction}, 8'(m_dir));
            cyc();
            chk("frame.update_clr", {7'd0, bus.update}, 8'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 4'b0;
        bus.frame_end = 1'b0;
        set_pix(0, 0, 0, 0);
        model_reset();
        repeat (3) cyc();
        check_outputs("reset");
        chk("reset.update", {7'd0, bus.update}, 8'd0);
        chk("reset.collision", {6'd0, bus.collision}, 8'd0);
        reset_n = 1'b1;
        cyc();

        // Start with RIGHT, moves every FPS frames.
        press(4'b1000);
        for (int i = 0; i < 2 * FPS + 1; i++) frame(0);

        // Turn UP, then DOWN (reverse, ignored) and LEFT within one step.
        press(4'b0001);
        while (m_frames != 0 || m_dir != 1) frame(0);
        press(4'b0010);
        press(4'b0100);
        for (int i = 0; i < FPS; i++) frame(0);
        press(4'b1000);
        for (int i = 0; i < FPS; i++) frame(0);
        // Simultaneous DOWN+RIGHT: DOWN wins.
        press(4'b1010);
        for (int i = 0; i < FPS; i++) frame(0);

        // Apples, non-overlapping flags, then reset mid-collision pulse at score 5.
        for (int i = 0; i < 4; i++) frame(1);
        frame(7);
        frame(1, 1'b1);

        // New game from simultaneous press (UP has priority), saturate score.
        press(4'b1001);
        frame(6);
        for (int i = 0; i < 256; i++) frame(1);
        frame(1);

        // Fatal and apple in one frame, then the game-over window with presses ignored.
        frame(3);
        for (int i = 0; i < GOF; i++) begin
            if (i % 10 == 5) press(4'($urandom_range(1, 15)));
            frame(i % 2);
        end
        press(4'b0100);
        frame(5);
        for (int i = 0; i < GOF; i++) frame(0);
        press(4'b0010);
        for (int i = 0; i < 3; i++) frame(2);
        for (int i = 0; i < GOF; i++) frame(0);

        // Random play.
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 4 == 0) press(4'($urandom_range(1, 15)));
            frame(4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
